router_controller: RTL and testbench

//  Control FSM for the simple router datapath. Turns the four push-button levels
//  (writeDes, writeData, writeCheck, sendData) into single-cycle register enables,
//  in the order destination -> data -> checksum. It then routes the packet to port 1
//  or port 2, or raises the error flag. Sits between the top-level button inputs and

---
 rtl/router_controller.sv | 161 ++++++++++++++++
 tb/tb_router_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_controller.sv
// rtl/router_controller.sv - router control FSM: button edges to load strobes and port/error routing
module router_controller #(
    parameter int TIMEOUT = 100_000_000,
    parameter int CNT_W   = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic writeDes,
    input  logic writeData,
    input  logic writeCheck,
    input  logic sendData,
    input  logic errorData,
    input  logic desPort,
    output logic enableDes,
    output logic enableData,
    output logic enableCheck,
    output logic enablePort1,
    output logic enablePort2,
    output logic errorFlag,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WAIT_CHECK,
        EVAL,
        WAIT_SEND,
        DONE
    } stateType;

    stateType   state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic [3:0] btnLevel, btnMeta, btnSync, btnPrev, btnEdge;
    logic       desEdge, dataEdge, checkEdge, sendEdge, timeoutHit;
    logic       desNext, dataNext, checkNext, port1Next, port2Next, errorNext, busyNext;

    assign btnLevel = {sendData, writeCheck, writeData, writeDes};

    // Two-flop synchronizer plus edge register; keeps running while disabled so stale edges drain away.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btnMeta <= '0;
            btnSync <= '0;
            btnPrev <= '0;
        end else begin
            btnMeta <= btnLevel;
            btnSync <= btnMeta;
            btnPrev <= btnSync;
        end
    end

    assign btnEdge    = btnSync & ~btnPrev;
    assign desEdge    = btnEdge[0];
    assign dataEdge   = btnEdge[1];
    assign checkEdge  = btnEdge[2];
    assign sendEdge   = btnEdge[3];
    assign timeoutHit = (count == CNT_W'(TIMEOUT - 1));

    // Next-state, timeout counter and next-output decode; everything holds when enable is low.
    always_comb begin
        stateNext = state;
        countNext = count;
        desNext   = 1'b0;
        dataNext  = 1'b0;
        checkNext = 1'b0;
        port1Next = enablePort1;
        port2Next = enablePort2;
        errorNext = errorFlag;
        if (enable) begin
            case (state)
                IDLE, DONE: begin
                    if (desEdge) begin
                        stateNext = WAIT_DATA;
                        desNext   = 1'b1;
                        port1Next = 1'b0;
                        port2Next = 1'b0;
                        errorNext = 1'b0;
                    end
                end
                WAIT_DATA: begin
                    if (dataEdge) begin
                        stateNext = WAIT_CHECK;
                        dataNext  = 1'b1;
                    end else if (timeoutHit) begin
                        stateNext = DONE;
                        errorNext = 1'b1;
                    end else begin
                        countNext = count + CNT_W'(1);
                    end
                end
                WAIT_CHECK: begin
                    if (checkEdge) begin
                        stateNext = EVAL;
                        checkNext = 1'b1;
                    end else if (timeoutHit) begin
                        stateNext = DONE;
                        errorNext = 1'b1;
                    end else begin
                        countNext = count + CNT_W'(1);
                    end
                end
                EVAL: begin
                    stateNext = WAIT_SEND;
                end
                WAIT_SEND: begin
                    if (sendEdge) begin
                        stateNext = DONE;
                        if (errorData) begin
                            errorNext = 1'b1;
                        end else if (desPort) begin
                            port2Next = 1'b1;
                        end else begin
                            port1Next = 1'b1;
                        end
                    end else if (timeoutHit) begin
                        stateNext = DONE;
                        errorNext = 1'b1;
                    end else begin
                        countNext = count + CNT_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
            if (stateNext != state) begin
                countNext = '0;
            end
        end
        busyNext = (stateNext == WAIT_DATA) || (stateNext == WAIT_CHECK) ||
                   (stateNext == EVAL) || (stateNext == WAIT_SEND);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            enableDes   <= 1'b0;
            enableData  <= 1'b0;
            enableCheck <= 1'b0;
            enablePort1 <= 1'b0;
            enablePort2 <= 1'b0;
            errorFlag   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= stateNext;
            count       <= countNext;
            enableDes   <= desNext;
            enableData  <= dataNext;
            enableCheck <= checkNext;
            enablePort1 <= port1Next;
            enablePort2 <= port2Next;
            errorFlag   <= errorNext;
            busy        <= busyNext;
        end
    end

endmodule

// File: tb/tb_router_controller.sv
// tb/tb_router_controller.sv - self-checking bench for router_controller
module tb_router_controller;

    localparam int TIMEOUT = 20;

    localparam int P_IDLE        = 0;
    localparam int P_AWAIT_DATA  = 1;
    localparam int P_AWAIT_CHECK = 2;
    localparam int P_SETTLE      = 3;
    localparam int P_AWAIT_SEND  = 4;
    localparam int P_DELIVERED   = 5;

    logic clock = 1'b0;
    logic reset, enable, writeDes, writeData, writeCheck, sendData, errorData, desPort;
    logic enableDes, enableData, enableCheck, enablePort1, enablePort2, errorFlag, busy;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    router_controller #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .writeDes(writeDes), .writeData(writeData), .writeCheck(writeCheck), .sendData(sendData),
        .errorData(errorData), .desPort(desPort),
        .enableDes(enableDes), .enableData(enableData), .enableCheck(enableCheck),
        .enablePort1(enablePort1), .enablePort2(enablePort2), .errorFlag(errorFlag), .busy(busy)
    );

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Behavioural model: a press is a 0->1 in the sampled history, acted on two edges later.
    int   mPhase, stall, prevPhase;
    logic [2:0] hDes, hData, hCheck, hSend;
    logic pDes, pData, pCheck, pSend;
    logic mDes, mData, mCheck, mPort1, mPort2, mErr, mBusy;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mPhase = P_IDLE; stall = 0;
            hDes = '0; hData = '0; hCheck = '0; hSend = '0;
            mDes = 0; mData = 0; mCheck = 0; mPort1 = 0; mPort2 = 0; mErr = 0; mBusy = 0;
        end else begin
            pDes   = hDes[1]   & ~hDes[2];
            pData  = hData[1]  & ~hData[2];
            pCheck = hCheck[1] & ~hCheck[2];
            pSend  = hSend[1]  & ~hSend[2];
            hDes   = {hDes[1:0], writeDes};
            hData  = {hData[1:0], writeData};
            hCheck = {hCheck[1:0], writeCheck};
            hSend  = {hSend[1:0], sendData};
            mDes = 0; mData = 0; mCheck = 0;
            if (enable) begin
                prevPhase = mPhase;
                case (mPhase)
                    P_IDLE, P_DELIVERED: if (pDes) begin
                        mPhase = P_AWAIT_DATA; mDes = 1; mPort1 = 0; mPort2 = 0; mErr = 0;
                    end
                    P_AWAIT_DATA:  if (pData)  begin mPhase = P_AWAIT_CHECK; mData = 1; end
                    P_AWAIT_CHECK: if (pCheck) begin mPhase = P_SETTLE; mCheck = 1; end
                    P_SETTLE:      mPhase = P_AWAIT_SEND;
                    P_AWAIT_SEND:  if (pSend) begin
                        mPhase = P_DELIVERED;
                        mErr   = errorData;
                        mPort1 = !errorData && !desPort;
                        mPort2 = !errorData && desPort;
                    end
                    default: ;
                endcase
                if (mPhase != prevPhase) begin
                    stall = 0;
                end else if (mPhase inside {P_AWAIT_DATA, P_AWAIT_CHECK, P_AWAIT_SEND}) begin
                    stall++;
                    if (stall == TIMEOUT) begin
                        mPhase = P_DELIVERED; mErr = 1; stall = 0;
                    end
                end
            end
            mBusy = mPhase inside {P_AWAIT_DATA, P_AWAIT_CHECK, P_SETTLE, P_AWAIT_SEND};
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clock) begin
        checkBit("enableDes",   enableDes,   mDes);
        checkBit("enableData",  enableData,  mData);
        checkBit("enableCheck", enableCheck, mCheck);
        checkBit("enablePort1", enablePort1, mPort1);
        checkBit("enablePort2", enablePort2, mPort2);
        checkBit("errorFlag",   errorFlag,   mErr);
        checkBit("busy",        busy,        mBusy);
    end

    task automatic setBtn(input int b, input logic v);
        case (b)
            0: writeDes   = v;
            1: writeData  = v;
            2: writeCheck = v;
            default: sendData = v;
        endcase
    endtask

    // Press button b for 'hold' cycles; expWhich: 0 none, 1 enableDes, 2 enableData, 3 enableCheck.
    task automatic press(input int b, input int hold, input int expWhich);
        int firstAt, pulses, which;
        firstAt = -1; pulses = 0; which = 0;
        setBtn(b, 1'b1);
        for (int i = 1; i <= hold + 4; i++) begin
            @(negedge clock);
            if (i == hold) setBtn(b, 1'b0);
            if (enableDes | enableData | enableCheck) begin
                pulses++;
                if (firstAt < 0) begin
                    firstAt = i;
                    which = enableDes ? 1 : (enableData ? 2 : 3);
                end
            end
        end
        checkInt($sformatf("strobePulses_btn%0d", b), pulses, (expWhich != 0) ? 1 : 0);
        if (expWhich != 0) begin
            checkInt($sformatf("strobeLatency_btn%0d", b), firstAt, 3);
            checkInt($sformatf("strobeWhich_btn%0d", b), which, expWhich);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, "_enableDes"},   enableDes,   1'b0);
        checkBit({tag, "_enableData"},  enableData,  1'b0);
        checkBit({tag, "_enableCheck"}, enableCheck, 1'b0);
        checkBit({tag, "_enablePort1"}, enablePort1, 1'b0);
        checkBit({tag, "_enablePort2"}, enablePort2, 1'b0);
        checkBit({tag, "_errorFlag"},   errorFlag,   1'b0);
        checkBit({tag, "_busy"},        busy,        1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        reset = 0; enable = 1; writeDes = 0; writeData = 0; writeCheck = 0; sendData = 0;
        errorData = 0; desPort = 0;
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        reset = 1;
        repeat (3) @(negedge clock);

        // 1: good packet to port 1
        press(0, 1, 1); press(1, 1, 2); press(2, 1, 3); press(3, 1, 0);
        checkBit("t1_port1", enablePort1, 1'b1);
        checkBit("t1_port2", enablePort2, 1'b0);
        checkBit("t1_error", errorFlag, 1'b0);
        checkBit("t1_busy",  busy, 1'b0);

        // 2: port 2, then a new writeDes clears port 2 alongside the enableDes pulse
        desPort = 1;
        press(0, 1, 1); press(1, 1, 2); press(2, 1, 3); press(3, 1, 0);
        checkBit("t2_port2", enablePort2, 1'b1);
        checkBit("t2_port1", enablePort1, 1'b0);
        setBtn(0, 1'b1);
        @(negedge clock); setBtn(0, 1'b0);
        @(negedge clock);
        checkBit("t2_port2_held", enablePort2, 1'b1);
        @(negedge clock);
        checkBit("t2_des_pulse", enableDes, 1'b1);
        checkBit("t2_port2_clear", enablePort2, 1'b0);
        repeat (2) @(negedge clock);

        // 3: checksum error at send
        press(1, 1, 2); press(2, 1, 3);
        errorData = 1;
        press(3, 1, 0);
        checkBit("t3_error", errorFlag, 1'b1);
        checkBit("t3_port1", enablePort1, 1'b0);
        checkBit("t3_port2", enablePort2, 1'b0);
        errorData = 0; desPort = 0;

        // 4: out-of-order presses ignored, long hold gives one pulse
        press(0, 1, 1); press(2, 1, 0); press(3, 1, 0);
        checkBit("t4_still_busy", busy, 1'b1);
        press(1, 10, 2); press(2, 1, 3); press(3, 1, 0);
        checkBit("t4_port1", enablePort1, 1'b1);

        // 5: timeout after writeDes
        press(0, 1, 1);
        repeat (17) @(negedge clock);
        checkBit("t5_no_timeout_yet", errorFlag, 1'b0);
        checkBit("t5_busy_before", busy, 1'b1);
        @(negedge clock);
        checkBit("t5_timeout_error", errorFlag, 1'b1);
        checkBit("t5_busy_after", busy, 1'b0);

        // 5b: enable low for 50 cycles mid-wait, with a discarded writeData press
        desPort = 1;
        press(0, 1, 1);
        enable = 0;
        strobes = 0;
        for (int i = 1; i <= 50; i++) begin
            if (i == 10) writeData = 1;
            if (i == 11) writeData = 0;
            @(negedge clock);
            if (enableDes | enableData | enableCheck) strobes++;
        end
        checkInt("t5b_hold_strobes", strobes, 0);
        checkBit("t5b_hold_error", errorFlag, 1'b0);
        checkBit("t5b_hold_busy", busy, 1'b1);
        enable = 1;
        repeat (4) @(negedge clock);
        checkBit("t5b_discarded_data", enableData, 1'b0);
        press(1, 1, 2); press(2, 1, 3); press(3, 1, 0);
        checkBit("t5b_port2", enablePort2, 1'b1);
        desPort = 0;

        // 6: reset in WAIT_SEND, then normal restart
        press(0, 1, 1); press(1, 1, 2); press(2, 1, 3);
        checkBit("t6_busy_before_reset", busy, 1'b1);
        #2 reset = 0;
        #1 checkAllZero("t6_reset");
        @(negedge clock);
        reset = 1;
        repeat (2) @(negedge clock);
        press(0, 1, 1);
        checkBit("t6_restart_busy", busy, 1'b1);
        press(1, 1, 2); press(2, 1, 3); press(3, 1, 0);
        checkBit("t6_port1", enablePort1, 1'b1);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
